// File: rtl/adc_sample_packer_pkg.sv
// Shared definitions for the ADC sample packer: default geometry, slot field
// offsets and parameter-legality helpers.
package adc_sample_packer_pkg;

  localparam int DEF_SAMPLE_WIDTH   = 12;
  localparam int DEF_CH_WIDTH       = 3;
  localparam int DEF_SLOT_WIDTH     = 16;
  localparam int DEF_SLOTS          = 4;
  localparam int DEF_DATA_WIDTH     = 64;
  localparam int DEF_DROP_CNT_WIDTH = 16;

  // Slot layout: {valid, channel, zero pad, sample}
  function automatic int valid_pos(input int slot_width);
    return slot_width - 1;
  endfunction

  function automatic int ch_lsb(input int slot_width, input int ch_width);
    return slot_width - 1 - ch_width;
  endfunction

  function automatic int idx_width(input int slots);
    return (slots > 1) ? $clog2(slots) : 1;
  endfunction

  function automatic bit params_ok(input int sample_width, input int ch_width,
                                   input int slot_width, input int slots,
                                   input int data_width);
    return (slots >= 1) && (slot_width >= sample_width + ch_width + 1) &&
           (data_width == slots * slot_width);
  endfunction

endpackage

// File: rtl/adc_pack_slot_reg.sv
// SLOTS-deep slot accumulator with write index and "full word waiting" flag.
// Exposes the accumulator contents including any slot being written this cycle.
module adc_pack_slot_reg
  import adc_sample_packer_pkg::*;
#(
  parameter int SLOT_WIDTH = DEF_SLOT_WIDTH,
  parameter int SLOTS      = DEF_SLOTS,
  parameter int IDX_W      = idx_width(DEF_SLOTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fill,
  input  logic [SLOT_WIDTH-1:0]       fill_slot,
  input  logic                        clear,
  input  logic                        set_full,
  output logic [SLOTS*SLOT_WIDTH-1:0] acc_word,
  output logic [IDX_W-1:0]            idx,
  output logic                        acc_full,
  output logic                        at_last
);

  logic [SLOTS*SLOT_WIDTH-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        full_q, full_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    acc_word = acc_q;
    for (int k = 0; k < SLOTS; k++) begin
      if (fill && idx_q == IDX_W'(k)) acc_word[k*SLOT_WIDTH +: SLOT_WIDTH] = fill_slot;
    end
    acc_d  = clear ? '0 : acc_word;
    idx_d  = clear ? '0 : (fill ? idx_q + 1'b1 : idx_q);
    full_d = clear ? 1'b0 : (set_full | full_q);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the slot array is a handful of flops, not a RAM, so it is reset like any other state.
      acc_q  <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      idx_q  <= idx_d;
      full_q <= full_d;
    end
  end

  assign idx      = idx_q;
  assign acc_full = full_q;
  assign at_last  = (idx_q == IDX_W'(SLOTS - 1));

endmodule

// File: rtl/adc_sample_packer.sv
// Packs channel-tagged ADC samples into FIFO words, holds one finished word
// against backpressure and counts samples dropped while both stages are full.
module adc_sample_packer
  import adc_sample_packer_pkg::*;
#(
  parameter int SAMPLE_WIDTH   = DEF_SAMPLE_WIDTH,
  parameter int CH_WIDTH       = DEF_CH_WIDTH,
  parameter int SLOT_WIDTH     = DEF_SLOT_WIDTH,
  parameter int SLOTS          = DEF_SLOTS,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int DROP_CNT_WIDTH = DEF_DROP_CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]   sample_data,
  input  logic [CH_WIDTH-1:0]       sample_ch,
  input  logic                      flush,
  input  logic                      fifo_clear,
  input  logic                      fifo_full,
  output logic                      adc_wr_en,
  output logic [DATA_WIDTH-1:0]     adc_data,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt,
  output logic                      overflow,
  output logic                      busy
);

  localparam int IDX_W     = idx_width(SLOTS);
  localparam int VALID_POS = valid_pos(SLOT_WIDTH);
  localparam int CH_LSB    = ch_lsb(SLOT_WIDTH, CH_WIDTH);

  if (!params_ok(SAMPLE_WIDTH, CH_WIDTH, SLOT_WIDTH, SLOTS, DATA_WIDTH)) begin : g_bad_params
    $error("adc_sample_packer: illegal slot geometry");
  end

  function automatic logic [SLOT_WIDTH-1:0] pack_slot(input logic [CH_WIDTH-1:0]     ch,
                                                      input logic [SAMPLE_WIDTH-1:0] s);
    logic [SLOT_WIDTH-1:0] w;
    w                     = '0;
    w[VALID_POS]          = 1'b1;
    w[CH_LSB +: CH_WIDTH] = ch;
    w[SAMPLE_WIDTH-1:0]   = s;
    return w;
  endfunction

  logic                      pend_valid_q, pend_valid_d;
  logic [DATA_WIDTH-1:0]     pend_data_q, pend_data_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                      overflow_q, overflow_d;

  logic                  accept, drop, pend_free, word_done, move, hold, slot_clear;
  logic [DATA_WIDTH-1:0] acc_word;
  logic [IDX_W-1:0]      idx;
  logic                  acc_full, at_last;

  always_comb begin
    accept    = sample_valid & enable & ~acc_full & ~fifo_clear;
    drop      = sample_valid & enable &  acc_full & ~fifo_clear;
    adc_wr_en = pend_valid_q & ~fifo_full & ~fifo_clear;
    pend_free = ~pend_valid_q | adc_wr_en;
    // A held full word keeps asking to move until the pend stage frees up.
    word_done  = acc_full | (accept & at_last) | (flush & ((idx != '0) | accept));
    move       = word_done & pend_free & ~fifo_clear;
    hold       = word_done & ~pend_free & ~fifo_clear;
    slot_clear = move | fifo_clear;

    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    if (fifo_clear) begin
      pend_valid_d = 1'b0;
    end else if (move) begin
      pend_valid_d = 1'b1;
      pend_data_d  = acc_word;
    end else if (adc_wr_en) begin
      pend_valid_d = 1'b0;
    end

    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    overflow_d = overflow_q | drop;
  end

  adc_pack_slot_reg #(
    .SLOT_WIDTH (SLOT_WIDTH),
    .SLOTS      (SLOTS),
    .IDX_W      (IDX_W)
  ) u_slot_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .fill      (accept),
    .fill_slot (pack_slot(sample_ch, sample_data)),
    .clear     (slot_clear),
    .set_full  (hold),
    .acc_word  (acc_word),
    .idx       (idx),
    .acc_full  (acc_full),
    .at_last   (at_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      drop_cnt_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      drop_cnt_q   <= drop_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  assign adc_data = pend_data_q;
  assign drop_cnt = drop_cnt_q;
  assign overflow = overflow_q;
  assign busy     = (idx != '0) | acc_full | pend_valid_q;

endmodule
